// File: rtl/video_text_display_if.sv
// video_text_display_if: text RAM write port, font ROM port and VGA outputs of the text display
interface video_text_display_if;
  logic [11:0] video_ram_addr;
  logic [15:0] video_ram_data;
  logic        video_ram_we;
  logic [11:0] glyph_addr;
  logic [7:0]  glyph_data;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        vga_hsync, vga_vsync, vga_de, vblank;
  modport master (
    output video_ram_addr, video_ram_data, video_ram_we, glyph_data,
    input  glyph_addr, vga_r, vga_g, vga_b, vga_hsync, vga_vsync, vga_de, vblank
  );
  modport slave (
    input  video_ram_addr, video_ram_data, video_ram_we, glyph_data,
    output glyph_addr, vga_r, vga_g, vga_b, vga_hsync, vga_vsync, vga_de, vblank
  );
endinterface

// File: rtl/video_text_display.sv
// video_text_display: 80x25 text-mode 640x480 VGA generator with internal cell RAM and 4-stage fetch pipeline
module video_text_display (
  input logic clk,
  input logic reset,
  video_text_display_if.slave bus
);
  localparam logic [6:0] BLANK = 7'b0011000;
  logic [15:0] ram [0:1999];
  logic [15:0] cell_q;
  logic [9:0] h, v;
  logic [8:0] vy;
  logic [10:0] rd_addr;
  logic vis, txt, bit_on;
  logic [3:0] idx, line1;
  logic [6:0] c0, c1, c2, c3;
  logic [7:0] at2, at3;

  function automatic logic [11:0] pal(input logic [3:0] c);
    logic [11:0] o;
    for (int k = 0; k < 3; k++) o[4*k +: 4] = c[k] ? (c[3] ? 4'hF : 4'hA) : (c[3] ? 4'h5 : 4'h0);
    return o;
  endfunction

  always_ff @(posedge clk)
    if (reset) begin
      h <= '0;
      v <= '0;
    end else begin
      h <= (h == 10'd799) ? '0 : h + 10'd1;
      if (h == 10'd799) v <= (v == 10'd524) ? '0 : v + 10'd1;
    end

  always_comb begin
    vy = 9'(v - 10'd40);
    vis = (h < 10'd640) && (v < 10'd480);
    txt = vis && (v >= 10'd40) && (v < 10'd440);
    rd_addr = txt ? 11'(vy[8:4]) * 11'd80 + 11'(h[9:3]) : '0;
    c0 = {vis, txt, !(h >= 10'd656 && h < 10'd752), !(v == 10'd490 || v == 10'd491), h[2:0]};
    bit_on = bus.glyph_data[3'd7 - c3[2:0]];
    idx = !c3[5] ? 4'd0 : bit_on ? at3[3:0] : at3[7:4];
  end

  // Read-first single-port-pair RAM; no reset so contents survive it
  always_ff @(posedge clk) begin
    if (bus.video_ram_we && bus.video_ram_addr < 12'd2000) ram[bus.video_ram_addr[10:0]] <= bus.video_ram_data;
    cell_q <= ram[rd_addr];
  end

  // c*: {vis, txt, hsync, vsync, pixel-in-cell}; c3 waits out the font ROM latency
  always_ff @(posedge clk)
    if (reset) begin
      c1 <= BLANK;
      c2 <= BLANK;
      c3 <= BLANK;
      line1 <= '0;
      at2 <= '0;
      at3 <= '0;
      bus.glyph_addr <= '0;
      {bus.vga_r, bus.vga_g, bus.vga_b} <= '0;
      bus.vga_hsync <= 1'b1;
      bus.vga_vsync <= 1'b1;
      bus.vga_de <= 1'b0;
    end else begin
      c1 <= c0;
      line1 <= vy[3:0];
      c2 <= c1;
      at2 <= cell_q[15:8];
      bus.glyph_addr <= {cell_q[7:0], line1};
      c3 <= c2;
      at3 <= at2;
      {bus.vga_r, bus.vga_g, bus.vga_b} <= c3[6] ? pal(idx) : '0;
      bus.vga_hsync <= c3[4];
      bus.vga_vsync <= c3[3];
      bus.vga_de <= c3[6];
    end

  assign bus.vblank = v >= 10'd480;
endmodule

// File: doc/video_text_display.md
VIDEO_TEXT_DISPLAY -- requirements
Module: video_text_display

Interface
REQ-001 The block SHALL have one clock and a synchronous active-high reset; all ports are listed below.
- clk  in  1  pixel clock, 25 MHz nominal.
- reset  in  1  synchronous, active-high.
- video_ram_addr  in  12  text-cell write address (cell index).
- video_ram_data  in  16  cell word: [7:0] char code, [11:8] fg colour, [15:12] bg colour.
- video_ram_we  in  1  write strobe, one cell per asserted clock.
- glyph_addr  out  12  {char[7:0], glyph_line[3:0]} to the external font ROM.
- glyph_data  in  8  font row, valid exactly 1 clk after glyph_addr; bit7 = leftmost pixel.
- vga_r, vga_g, vga_b  out  4 each  pixel colour.
- vga_hsync, vga_vsync  out  1 each  sync, active-low.
- vga_de  out  1  visible-area flag.
- vblank  out  1  high while v_count >= 480 (undelayed), for CPU polling.

Function
REQ-002 Text RAM SHALL be internal, 2000 x 16 bits, one write port and one read port, holding an 80 x 25 grid, row-major: cell = row*80 + col.
REQ-003 A write with video_ram_we=1 and video_ram_addr < 2000 SHALL store video_ram_data at the next clk edge; addresses 2000..4095 SHALL be ignored.
REQ-004 When a read and a write hit the same cell in the same clk, the read SHALL return the old data (read-first); the new data appears from the next fetch onward.
REQ-005 h_count SHALL run 0..799 and wrap to 0; v_count SHALL increment when h_count wraps, run 0..524, and wrap to 0.
REQ-006 Visible area: h_count < 640 and v_count < 480.
REQ-006a Text area: visible and 40 <= v_count < 440.
REQ-006b Text area geometry: col = h_count[9:3], row = (v_count-40)>>4, glyph_line = (v_count-40)[3:0].
REQ-007 hsync SHALL be low for h_count 656..751; vsync SHALL be low for v_count 490..491.
REQ-008 Fetch pipeline, aligned to the counters:
- stage 1: text RAM read of the cell;
- stage 2: glyph_addr driven, cell attributes registered;
- stage 3: glyph_data captured and the pixel selected by h_count[2:0] (0 = bit7);
- stage 4: colour mapped into the output registers.
REQ-009 vga_r/g/b, vga_hsync, vga_vsync and vga_de SHALL reflect counter value (h,v) exactly 4 clks after the counters held (h,v).
REQ-009a Sync and colour SHALL remain mutually aligned.
REQ-010 Pixel colour selection:
- glyph bit = 1 selects fg; glyph bit = 0 selects bg;
- visible but outside the text area: colour index 0;
- non-visible: all channels 0 and vga_de = 0.
REQ-011 Palette: colour index bit3 = I, bits2..0 = R,G,B.
- Each channel = 4'hF if bit=1 and I=1; 4'hA if bit=1 and I=0; 4'h5 if bit=0 and I=1; 4'h0 otherwise.
REQ-012 glyph_addr is a don't-care outside the text area; the font ROM is read-only and the block SHALL NOT depend on its value there.

Reset
REQ-013 While reset=1, on each clk:
- h_count = v_count = 0;
- vga_r/g/b = 0, vga_hsync = 1, vga_vsync = 1, vga_de = 0, vblank = 0, glyph_addr = 0;
- all pipeline stages SHALL be loaded with blank/inactive values.
REQ-014 Text RAM contents SHALL NOT be cleared by reset; writes presented during reset SHALL still be stored.
REQ-015 Reset asserted mid-frame SHALL abort the frame; the first clk after release has h_count = v_count = 0.
REQ-015a No stale pixel or sync pulse SHALL emerge from the pipeline after reset releases.

Verification
REQ-016 The bench SHALL cover these directed scenarios:
- Sync timing: release reset, free-run. First vga_hsync fall 660 clks after release; low 96 clks; period 800 clks. vga_vsync low for 1600 clks every 420000 clks. vblank rises at v_count 480.
- Cell 0 write: write addr 0, data 0x8041; glyph_data models a ROM returning 0x80 for {0x41, line 0}.
  - Line 40: glyph_addr = 0x410 during text fetch.
  - Output pixel 0 = 0x000 (fg 0); pixels 1..7 = 0x555 (bg 8, I=1).
- Last cell: write addr 1999, data 0xC1FF with ROM 0xFF for char 0xFF. Pixels h 632..639, v 424..439 = fg 1 -> (0,0,A).
- Out-of-range write: write addr 2000 and 0xFFF with 0xFFFF. No visible cell changes; rows 0..24 match the previous frame bit-exactly.
- Border and read-first:
  - v 0..39: vga_de = 1, colour 0.
  - A same-clk write to the cell being fetched shows the old glyph this frame and the new glyph next frame.
- Reset mid-line: assert reset at h = 300, v = 200 for 3 clks. Outputs are at reset values during reset. The next hsync fall comes 660 clks after release, and no partial pulse appears.
